slot_i2s_tx: RTL

- Synthesizable I2S master transmitter on the host/FPGA side of a slot in DAC2 or DAC8 mode.
- Drives BCK, LRCK and 1 or 4 serial data lines onto slotdata[5:0] and pulls one sample frame per LRCK period from an upstream FIFO.
- Produces the bitstream that the slot's I2S receivers (DAC chips, or i2s_receiver in simulation) consume.

---
 rtl/slot_i2s_tx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/slot_i2s_tx.sv
// slot_i2s_tx: I2S master transmitter for a DAC2/DAC8 slot.
// Pulls one 8-channel frame per LRCK period from a first-word-fall-through
// source and serialises channel 2n (left) / 2n+1 (right) onto sdata[n].
//
//   state | meaning
//   IDLE  | outputs and counters held at 0, nothing consumed
//   RUN   | bit clock running, one frame every 2*SLOT_WIDTH bit periods
module slot_i2s_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SLOT_WIDTH   = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      chan,
  input  logic [9:0]                clk_divide_ratio,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*SAMPLE_WIDTH-1:0] in_data,
  output logic                      bck,
  output logic                      lrck,
  output logic [3:0]                sdata,
  output logic                      underrun
);
  localparam int DW = 8*SAMPLE_WIDTH;
  localparam int BW = $clog2(2*SLOT_WIDTH);
  localparam int IW = $clog2(DW);
  localparam logic [BW-1:0] LAST_BIT = BW'(2*SLOT_WIDTH-1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [2:0]    half_q, half_d;
  logic [2:0]    phase_q, phase_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic          chan_q, chan_d;
  logic [DW-1:0] shadow_q, shadow_d;
  logic          bck_q, bck_d;
  logic          lrck_q, lrck_d;
  logic [3:0]    sdata_q, sdata_d;
  logic          in_ready_q, in_ready_d;
  logic          underrun_q, underrun_d;

  logic          load;
  logic          new_bit;
  logic [2:0]    half_in;
  logic [DW-1:0] frame_in;
  logic          right_half;
  logic [BW-1:0] pos;
  logic [IW-1:0] idx;
  logic          unused_ratio_bits;

  // Only the multiples of 128 matter; the low ratio bits are truncated away.
  assign unused_ratio_bits = ^clk_divide_ratio[6:0];
  assign half_in  = (clk_divide_ratio[9:7] == 3'd0) ? 3'd1 : clk_divide_ratio[9:7];
  // In 2-channel mode only channels 0/1 are kept so lines 1-3 stay silent.
  assign frame_in = !in_valid ? '0 :
                    chan      ? in_data :
                    {{(DW-2*SAMPLE_WIDTH){1'b0}}, in_data[2*SAMPLE_WIDTH-1:0]};

  // Sequencing: bck phase timing, bit counter, frame load points.
  always_comb begin
    state_d    = state_q;
    half_d     = half_q;
    phase_d    = phase_q;
    bit_cnt_d  = bit_cnt_q;
    chan_d     = chan_q;
    shadow_d   = shadow_q;
    bck_d      = bck_q;
    in_ready_d = 1'b0;
    underrun_d = 1'b0;
    load       = 1'b0;
    new_bit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // Partial frame is abandoned silently.
          state_d   = IDLE;
          phase_d   = 3'd0;
          bit_cnt_d = '0;
          bck_d     = 1'b0;
        end else if (phase_q != 3'd0) begin
          phase_d = phase_q - 3'd1;
        end else if (!bck_q) begin
          bck_d   = 1'b1;
          phase_d = half_q - 3'd1;
        end else begin
          new_bit = 1'b1;
          if (bit_cnt_q == LAST_BIT) load = 1'b1;
          else bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
    endcase
    // Divider and mode are sampled only here so a frame never changes shape.
    if (load) begin
      bit_cnt_d  = '0;
      half_d     = half_in;
      chan_d     = chan;
      shadow_d   = frame_in;
      in_ready_d = 1'b1;
      underrun_d = !in_valid;
    end
    if (load || new_bit) begin
      bck_d   = 1'b0;
      phase_d = half_d - 3'd1;
    end
  end

  // Serial data for the bit period that starts with the next bck low phase.
  always_comb begin
    lrck_d     = 1'b0;
    sdata_d    = 4'b0;
    right_half = 1'b0;
    pos        = '0;
    idx        = '0;
    if (state_d == RUN) begin
      right_half = (bit_cnt_d >= BW'(SLOT_WIDTH));
      pos        = right_half ? bit_cnt_d - BW'(SLOT_WIDTH) : bit_cnt_d;
      lrck_d     = right_half;
      // Position 0 is the one-bck I2S delay; MSB follows at position 1.
      if (pos != '0 && pos <= BW'(SAMPLE_WIDTH)) begin
        for (int n = 0; n < 4; n++) begin
          idx = IW'((2*n + int'(right_half))*SAMPLE_WIDTH + SAMPLE_WIDTH - int'(pos));
          if (n == 0 || chan_d) sdata_d[n] = shadow_d[idx];
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      half_q     <= 3'd0;
      phase_q    <= 3'd0;
      bit_cnt_q  <= '0;
      chan_q     <= 1'b0;
      shadow_q   <= '0;
      bck_q      <= 1'b0;
      lrck_q     <= 1'b0;
      sdata_q    <= 4'b0;
      in_ready_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      phase_q    <= phase_d;
      bit_cnt_q  <= bit_cnt_d;
      chan_q     <= chan_d;
      shadow_q   <= shadow_d;
      bck_q      <= bck_d;
      lrck_q     <= lrck_d;
      sdata_q    <= sdata_d;
      in_ready_q <= in_ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign bck      = bck_q;
  assign lrck     = lrck_q;
  assign sdata    = sdata_q;
  assign in_ready = in_ready_q;
  assign underrun = underrun_q;
endmodule
